// File: rtl/serial_parity_receiver_pkg.sv
// Shared frame definitions for the XOR-parity serial link (receiver and transmitter).
package serial_parity_receiver_pkg;

  // Deframer FSM state encodings
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  // Frame bit-level constants
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Default frame geometry
  localparam int unsigned DEF_DATA_W = 8;

endpackage : serial_parity_receiver_pkg

// File: rtl/xor2_nor_cell.sv
// Two-input XOR built only from NOR primitives: y = a ^ b.
module xor2_nor_cell (
  input  logic a,
  input  logic b,
  output logic y
);

  logic n_ab;
  logic n_a;
  logic n_b;
  logic xnor_ab;

  // Classic four-NOR XNOR followed by a NOR inverter
  nor u_nor_ab   (n_ab, a, b);
  nor u_nor_a    (n_a, a, n_ab);
  nor u_nor_b    (n_b, b, n_ab);
  nor u_nor_xnor (xnor_ab, n_a, n_b);
  nor u_nor_inv  (y, xnor_ab, xnor_ab);

endmodule : xor2_nor_cell

// File: rtl/serial_parity_receiver.sv
// Deframes start / DATA_W data (LSB first) / parity / stop into words on a valid/ready port.
module serial_parity_receiver
  import serial_parity_receiver_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  logic [1:0]        state_q,      state_d;
  logic [CNT_W-1:0]  bit_cnt_q,    bit_cnt_d;
  logic              acc_q,        acc_d;
  logic [DATA_W-1:0] shreg_q,      shreg_d;
  logic              perr_q,       perr_d;
  logic [DATA_W-1:0] data_out_q,   data_out_d;
  logic              out_valid_q,  out_valid_d;
  logic              parity_err_q, parity_err_d;
  logic              frame_err_q,  frame_err_d;
  logic              overrun_q,    overrun_d;

  logic              acc_x;
  logic              complete_c;

  // Running parity term acc ^ bit_in, shared by the DATA update and the PARITY check
  xor2_nor_cell u_acc_xor (
    .a (acc_q),
    .b (bit_in),
    .y (acc_x)
  );

  // Next-state: frame FSM (advances only on bit_valid) and output-register/handshake control
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    acc_d        = acc_q;
    shreg_d      = shreg_q;
    perr_d       = perr_q;
    data_out_d   = data_out_q;
    out_valid_d  = out_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;
    complete_c   = 1'b0;

    if (bit_valid) begin
      case (state_q)
        S_IDLE: begin
          if (bit_in == START_BIT) begin
            state_d   = S_DATA;
            acc_d     = 1'b0;
            bit_cnt_d = '0;
          end
        end
        S_DATA: begin
          for (int unsigned i = 0; i < DATA_W; i++) begin
            if (bit_cnt_q == CNT_W'(i)) begin
              shreg_d[i] = bit_in;
            end
          end
          acc_d     = acc_x;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = S_PARITY;
          end
        end
        S_PARITY: begin
          perr_d  = (acc_x != PARITY_ODD);
          state_d = S_STOP;
        end
        S_STOP: begin
          // Always return to IDLE; a 0 stop bit is only flagged, never resynced on
          complete_c = 1'b1;
          state_d    = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    if (complete_c) begin
      if (!out_valid_q || out_ready) begin
        // Output slot is free or being drained this cycle: load the new word
        data_out_d   = shreg_q;
        parity_err_d = perr_q;
        frame_err_d  = (bit_in != STOP_BIT);
        out_valid_d  = 1'b1;
      end else begin
        // Slot still held by an unaccepted word: drop the new one
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      acc_q        <= 1'b0;
      shreg_q      <= '0;
      perr_q       <= 1'b0;
      data_out_q   <= '0;
      out_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      acc_q        <= acc_d;
      shreg_q      <= shreg_d;
      perr_q       <= perr_d;
      data_out_q   <= data_out_d;
      out_valid_q  <= out_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data_out   = data_out_q;
  assign out_valid  = out_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule : serial_parity_receiver

// File: tb/tb_serial_parity_receiver.sv
// Directed bench for serial_parity_receiver with an expected-word scoreboard.
module tb_serial_parity_receiver;

  typedef struct packed {
    logic [7:0] d;
    logic       p;
    logic       f;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       bit_in;
  logic       bit_valid;
  logic       out_ready;
  logic [7:0] data_out;
  logic       out_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  logic [7:0] data_out_o;
  logic       out_valid_o;
  logic       parity_err_o;
  logic       frame_err_o;
  logic       overrun_o;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  serial_parity_receiver #(.DATA_W(8), .PARITY_ODD(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  serial_parity_receiver #(.DATA_W(8), .PARITY_ODD(1'b1)) dut_odd (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .data_out   (data_out_o),
    .out_valid  (out_valid_o),
    .out_ready  (out_ready),
    .parity_err (parity_err_o),
    .frame_err  (frame_err_o),
    .overrun    (overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model of the receiver's verdict for a frame, given its expected parity sense
  function automatic exp_t model(input logic [7:0] d, input logic par, input logic stop,
                                 input logic odd);
    exp_t e;
    e.d = d;
    e.p = ((^d) ^ par) != odd;
    e.f = ~stop;
    return e;
  endfunction

  task automatic send_bit(input logic b, input int gap, input logic rdy);
    for (int g = 0; g < gap; g++) begin
      bit_valid = 1'b0;
      bit_in    = 1'b1;
      @(posedge clk);
      #1;
    end
    bit_in    = b;
    bit_valid = 1'b1;
    out_ready = rdy;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    bit_in    = 1'b1;
    out_ready = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int gap, input logic rdy_at_stop);
    send_bit(1'b0, gap, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], gap, 1'b0);
    send_bit(par, gap, 1'b0);
    send_bit(stop, gap, rdy_at_stop);
  endtask

  task automatic check_word(input string tag);
    exp_t e;
    int   n = 0;
    while (out_valid !== 1'b1 && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'(1));
    chk({tag, "_sb_nonempty"}, 32'(q.size() != 0), 32'(1));
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({tag, "_data"}, 32'(data_out), 32'(e.d));
      chk({tag, "_perr"}, 32'(parity_err), 32'(e.p));
      chk({tag, "_ferr"}, 32'(frame_err), 32'(e.f));
    end
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_drained"}, 32'(out_valid), 32'(0));
    chk({tag, "_ovr_clr"}, 32'(overrun), 32'(0));
  endtask

  initial begin
    exp_t eo;
    rst_n     = 1'b0;
    bit_in    = 1'b1;
    bit_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_data", 32'(data_out), 32'(0));
    chk("rst_perr", 32'(parity_err), 32'(0));
    chk("rst_ferr", 32'(frame_err), 32'(0));
    chk("rst_ovr", 32'(overrun), 32'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: even-parity 0xA5, word visible one clock after the stop bit
    q.push_back(model(8'hA5, 1'b0, 1'b1, 1'b0));
    send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b0);
    chk("t1_latency", 32'(out_valid), 32'(1));
    check_word("t1");
    accept("t1");

    // 2: wrong parity bit for even; same frame is correct for an odd receiver
    q.push_back(model(8'hA5, 1'b1, 1'b1, 1'b0));
    send_frame(8'hA5, 1'b1, 1'b1, 0, 1'b0);
    check_word("t2");
    eo = model(8'hA5, 1'b1, 1'b1, 1'b1);
    chk("t2_odd_valid", 32'(out_valid_o), 32'(1));
    chk("t2_odd_perr", 32'(parity_err_o), 32'(eo.p));
    chk("t2_odd_data", 32'(data_out_o), 32'(eo.d));
    accept("t2");

    // 3: bad stop bit, then a following frame must decode normally
    q.push_back(model(8'h3C, ^8'h3C, 1'b0, 1'b0));
    send_frame(8'h3C, ^8'h3C, 1'b0, 0, 1'b0);
    check_word("t3");
    accept("t3");
    q.push_back(model(8'h5A, ^8'h5A, 1'b1, 1'b0));
    send_frame(8'h5A, ^8'h5A, 1'b1, 0, 1'b0);
    check_word("t3_next");
    accept("t3_next");

    // 4: consumer stalled, second frame dropped and overrun raised
    q.push_back(model(8'hA5, 1'b0, 1'b1, 1'b0));
    send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b0);
    send_frame(8'h3C, ^8'h3C, 1'b1, 0, 1'b0);
    check_word("t4");
    chk("t4_ovr", 32'(overrun), 32'(1));
    accept("t4");

    // Completion coinciding with a handshake replaces the word, no overrun
    q.push_back(model(8'h11, ^8'h11, 1'b1, 1'b0));
    send_frame(8'h11, ^8'h11, 1'b1, 0, 1'b0);
    check_word("t4b_first");
    q.push_back(model(8'h22, 1'b1, 1'b1, 1'b0));
    send_frame(8'h22, 1'b1, 1'b1, 0, 1'b1);
    check_word("t4b_second");
    chk("t4b_ovr", 32'(overrun), 32'(0));
    accept("t4b");

    // 5: sparse bit_valid with idle 1s must not false-start
    for (int i = 0; i < 5; i++) send_bit(1'b1, 2, 1'b0);
    chk("t5_idle", 32'(out_valid), 32'(0));
    q.push_back(model(8'hA5, 1'b0, 1'b1, 1'b0));
    send_frame(8'hA5, 1'b0, 1'b1, 2, 1'b0);
    check_word("t5");
    accept("t5");

    // 6: pending word plus partial frame, then a one-clock reset
    send_frame(8'h77, ^8'h77, 1'b0, 0, 1'b0);
    chk("t6_pending", 32'(out_valid), 32'(1));
    send_bit(1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("t6_rst_valid", 32'(out_valid), 32'(0));
    chk("t6_rst_data", 32'(data_out), 32'(0));
    chk("t6_rst_perr", 32'(parity_err), 32'(0));
    chk("t6_rst_ferr", 32'(frame_err), 32'(0));
    chk("t6_rst_ovr", 32'(overrun), 32'(0));
    q.push_back(model(8'h0F, ^8'h0F, 1'b1, 1'b0));
    send_frame(8'h0F, ^8'h0F, 1'b1, 0, 1'b0);
    check_word("t6");
    accept("t6");

    chk("sb_drained", 32'(q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_serial_parity_receiver
